// File: rtl/instr_loader.sv
// Program loader: packs UART bytes (MSB first) into instruction words and writes
// them to consecutive instruction-memory addresses until HALT or memory full.
module instr_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    MEM_DEPTH  = 64,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [BYTE_WIDTH-1:0]        i_rx_data,
  input  logic                         i_rx_done,
  output logic [DATA_WIDTH-1:0]        o_instruccion,
  output logic [DATA_WIDTH-1:0]        o_address,
  output logic                         o_wr_en,
  output logic                         o_loading,
  output logic                         o_done,
  output logic [$clog2(MEM_DEPTH):0]   o_word_count
);

  // state | meaning
  // IDLE  | no session since reset
  // RECV  | collecting bytes of the current word
  // WRITE | one-cycle write strobe for the completed word
  // DONE  | session finished (HALT seen or memory full)
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  localparam int BPW = DATA_WIDTH / BYTE_WIDTH;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CW  = $clog2(MEM_DEPTH) + 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [CW-1:0]  DEPTH_C   = CW'(MEM_DEPTH);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [BCW-1:0]          byte_cnt_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic                    wr_en_q;
  logic                    loading_q;
  logic                    done_q;
  logic [CW-1:0]           count_q;

  logic [DATA_WIDTH-1:0]   shift_d;
  logic [DATA_WIDTH-1:0]   addr_d;
  logic [CW-1:0]           count_d;

  assign shift_d = {shift_q[DATA_WIDTH-BYTE_WIDTH-1:0], i_rx_data};
  assign addr_d  = addr_q + DATA_WIDTH'(4);
  assign count_d = count_q + CW'(1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_q    <= S_RECV;
            loading_q  <= 1'b1;
            done_q     <= 1'b0;
            addr_q     <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
          end
        end
        S_RECV: begin
          if (i_rx_done) begin
            shift_q <= shift_d;
            if (byte_cnt_q == LAST_BYTE) begin
              instr_q    <= shift_d;
              byte_cnt_q <= '0;
              wr_en_q    <= 1'b1;
              state_q    <= S_WRITE;
            end else begin
              byte_cnt_q <= byte_cnt_q + BCW'(1);
            end
          end
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          count_q <= count_d;
          if (instr_q == HALT_WORD || count_d == DEPTH_C) begin
            state_q   <= S_DONE;
            loading_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            state_q <= S_RECV;
            addr_q  <= addr_d;
            // a byte landing during the write strobe starts the next word
            if (i_rx_done) begin
              shift_q    <= shift_d;
              byte_cnt_q <= BCW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_instruccion = instr_q;
  assign o_address     = addr_q;
  assign o_wr_en       = wr_en_q;
  assign o_loading     = loading_q;
  assign o_done        = done_q;
  assign o_word_count  = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed test-plan sequences plus random traffic, all
// checked every cycle against a transaction-level model of a load session.
module tb_instr_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0, i_start = 1'b0, i_rx_done = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic [31:0] o_instruccion, o_address;
  logic        o_wr_en, o_loading, o_done;
  logic [$clog2(DEPTH):0] o_word_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_loader #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(DEPTH),
                 .HALT_WORD(32'hFFFFFFFF)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_instruccion(o_instruccion), .o_address(o_address), .o_wr_en(o_wr_en),
    .o_loading(o_loading), .o_done(o_done), .o_word_count(o_word_count));

  // model: session flags, bytes of the word in flight, words written so far
  bit         m_active, m_done, m_pending;
  int         m_count;
  logic [7:0] m_bytes[$];
  logic [31:0] m_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task model_update(input bit rst, input bit st, input bit rxd, input logic [7:0] d);
    if (rst) begin
      m_active = 0; m_done = 0; m_pending = 0; m_count = 0; m_bytes = {};
    end else if (m_pending) begin
      m_pending = 0;
      m_count++;
      if (m_word == 32'hFFFFFFFF || m_count == DEPTH) begin
        m_active = 0; m_done = 1; m_bytes = {};
      end else if (rxd) begin
        m_bytes.push_back(d);
      end
    end else if (m_active) begin
      if (rxd) begin
        m_bytes.push_back(d);
        if (m_bytes.size() == 4) begin
          m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_pending = 1;
          m_bytes = {};
        end
      end
    end else if (st) begin
      m_active = 1; m_done = 0; m_count = 0; m_bytes = {};
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit rxd, input logic [7:0] d);
    int ea;
    i_reset = rst; i_start = st; i_rx_done = rxd; i_rx_data = d;
    @(posedge clk);
    model_update(rst, st, rxd, d);
    #1;
    i_reset = 0; i_start = 0; i_rx_done = 0;
    ea = m_active ? m_count * 4 : (m_done ? (m_count - 1) * 4 : 0);
    check("wr_en", 32'(o_wr_en), 32'(m_pending));
    check("loading", 32'(o_loading), 32'(m_active));
    check("done", 32'(o_done), 32'(m_done));
    check("word_count", 32'(o_word_count), 32'(m_count));
    check("address", o_address, 32'(ea));
    if (m_pending) check("instr", o_instruccion, m_word);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] v;
    v = w;
    for (int b = 3; b >= 0; b--) begin
      for (int g = 0; g < gap; g++) step(0, 0, 0, 8'h00);
      step(0, 0, 1, v[b*8 +: 8]);
    end
  endtask

  initial begin
    step(1, 0, 0, 8'h00);
    check("reset_instr", o_instruccion, 32'h0);
    step(0, 0, 1, 8'h55);               // bytes ignored in IDLE
    step(1, 1, 0, 8'h00);               // reset beats start
    check("rst_wins_loading", 32'(o_loading), 32'h0);

    // three words ending in HALT, then stray bytes
    step(0, 1, 0, 8'h00);
    send_word(32'h20010005, 1);
    step(0, 0, 0, 8'h00);
    check("after_first_addr", o_address, 32'd4);
    send_word(32'h00221820, 0);
    send_word(32'hFFFFFFFF, 2);
    step(0, 0, 0, 8'h00);
    check("halt_count", 32'(o_word_count), 32'd3);
    send_word(32'h12345678, 0);

    // memory-full stop after DEPTH words; extra word ignored
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) send_word(32'h01000000 + 32'(i), 1);
    step(0, 0, 0, 8'h00);
    check("full_addr", o_address, 32'd12);
    send_word(32'hCAFEF00D, 0);

    // reset mid-word discards the partial word
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h01);
    step(0, 0, 1, 8'h02);
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    send_word(32'hAABBCCDD, 0);

    // byte during WRITE becomes byte 0 of the next word; start in RECV ignored
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    send_word(32'h0A0B0C0D, 0);
    step(0, 0, 1, 8'h11);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h22);
    step(0, 0, 1, 8'h33);
    step(0, 0, 1, 8'h44);
    check("wr_byte_instr", o_instruccion, 32'h11223344);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      bit r, s, x;
      logic [7:0] d;
      r = ($urandom % 300) == 0;
      s = ($urandom % 25) == 0;
      x = ($urandom % 2) == 1;
      d = (($urandom % 2) == 0) ? 8'hFF : 8'($urandom);
      step(r, s, x, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Program loader that drives the pipeline top's instruction-memory load port: o_instruccion, o_address and o_loading connect to i_instruccion, i_address and i_loading.
- Assembles bytes arriving from the UART receiver (one-cycle i_rx_done strobe per byte) into 32-bit instruction words. Writes them to consecutive instruction-memory addresses.
- Holds the pipeline in load mode until a HALT word is written or memory is full, then releases it to run.

Parameters:
- DATA_WIDTH, 32, instruction/address width.
- BYTE_WIDTH, 8, UART byte width.
- MEM_DEPTH, 64, instruction memory depth in words.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins a load session.
- i_rx_data  in  BYTE_WIDTH  received byte; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle byte-valid strobe.
- o_instruccion  out  DATA_WIDTH  assembled instruction word.
- o_address  out  DATA_WIDTH  byte address of the word; steps by 4.
- o_wr_en  out  1  one-cycle write strobe for the instruction memory.
- o_loading  out  1  high for the whole load session; the pipeline is held in load mode.
- o_done  out  1  high once loading has finished; held until the next i_start or reset.
- o_word_count  out  $clog2(MEM_DEPTH)+1  number of words written in the current session.

Behaviour:
- Reset (synchronous, active-high), on the cycle i_reset=1:
  - State goes to IDLE.
  - All outputs are 0: o_instruccion, o_address, o_wr_en, o_loading, o_done, o_word_count.
  - Byte counter and shift register are cleared.
  - Reset mid-session aborts the session. A partial word is discarded and nothing is written.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - i_start=1 -> RECV; o_loading<=1, o_address<=0, o_word_count<=0, byte counter<=0.
  - i_rx_done is ignored.
- RECV:
  - Each i_rx_done shifts i_rx_data into the word, MSB first: word <= {word[23:0], i_rx_data}. Byte counter increments.
  - On the 4th byte, the next state is WRITE. o_instruccion takes the completed word and the byte counter goes to 0.
  - i_start is ignored.
- WRITE (exactly one cycle):
  - o_wr_en=1; o_instruccion and o_address are stable and valid.
  - If o_instruccion==HALT_WORD, or o_word_count+1==MEM_DEPTH -> DONE. o_loading<=0, o_done<=1, o_word_count<=o_word_count+1.
  - Otherwise -> RECV, with o_address<=o_address+4 and o_word_count<=o_word_count+1.
  - An i_rx_done in the WRITE cycle is accepted as byte 0 of the next word. It is ignored if the next state is DONE.
- DONE:
  - o_loading=0, o_done=1, o_wr_en=0; o_address and o_word_count hold their last values.
  - i_rx_done is ignored.
  - i_start=1 behaves as from IDLE (new session, o_done<=0). The same applies to i_start in IDLE.
- Timing:
  - o_wr_en is asserted in the cycle after the 4th byte's i_rx_done.
  - o_loading falls, and o_done rises, in the cycle after the final WRITE.
- Width/wrap rules:
  - The address is kept as a full DATA_WIDTH value.
  - It never exceeds (MEM_DEPTH-1)*4, because the MEM_DEPTH limit forces DONE before any wrap.
- Simultaneous i_reset and i_start: reset wins.
- o_wr_en is never asserted outside WRITE. o_loading is never high in IDLE or DONE.

Test Plan:
- Reset, then i_start, then bytes 20,01,00,05 -> one WRITE cycle with o_instruccion=32'h20010005, o_address=0, o_wr_en=1; state returns to RECV; o_address then 4.
- Three words (32'h20010005, 32'h00221820, 32'hFFFFFFFF) -> writes at addresses 0, 4, 8; after the third write o_loading=0, o_done=1, o_word_count=3; further bytes cause no writes.
- MEM_DEPTH=4 with 4 non-HALT words -> last write at address 12, then DONE with o_word_count=4; a 5th word's bytes are ignored.
- 2 bytes received, then i_reset for 1 cycle, then i_start and 4 bytes AA,BB,CC,DD -> a single write of 32'hAABBCCDD at address 0; no partial word is written.
- i_rx_done asserted in the WRITE cycle with byte 11, followed by 22,33,44 -> second write is 32'h11223344 at address 4.
- i_start pulsed during RECV -> ignored, address unchanged; i_start in DONE -> o_done=0, o_loading=1, o_address=0, o_word_count=0.
